// File: rtl/ex_result_stage.sv
// EX/MEM boundary register: captures ALU result/flags, resolves set/branch conditions,
// and squashes the one wrong-path instruction after a taken redirect. Optional: OFL_TRAP_EN.
module ex_result_stage #(
    parameter int WIDTH = 16,
    parameter int REGW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_ofl,
    input  logic             alu_cout,
    input  logic             alu_sign,
    input  logic [2:0]       cond,
    input  logic             is_set,
    input  logic             is_branch,
    input  logic             is_arith,
    input  logic [WIDTH-1:0] br_target,
    input  logic [REGW-1:0]  wr_reg,
    input  logic             wr_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [REGW-1:0]  wb_reg,
    output logic             wb_en,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             ofl_exc
);

    typedef enum logic [0:0] {NORMAL, SHADOW} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [REGW-1:0]  wb_reg_q, wb_reg_d;
    logic             wb_en_q, wb_en_d;
    logic             redirect_q, redirect_d;
    logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic             ofl_exc_q, ofl_exc_d;

    logic squash;
    logic live;
    logic c;

    function automatic logic cond_bit(input logic [2:0] sel, input logic z, input logic ofl,
                                      input logic cout, input logic sign);
        logic lt;
        lt = sign ^ ofl;
        case (sel)
            3'b000:  cond_bit = z;
            3'b001:  cond_bit = ~z;
            3'b010:  cond_bit = lt;
            3'b011:  cond_bit = ~lt;
            3'b100:  cond_bit = z | lt;
            3'b101:  cond_bit = cout;
            3'b110:  cond_bit = 1'b1;
            default: cond_bit = 1'b0;
        endcase
    endfunction

    assign squash = (state_q == SHADOW);
    assign live   = in_valid & ~squash;
    assign c      = cond_bit(cond, alu_z, alu_ofl, alu_cout, alu_sign);

    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        result_d      = result_q;
        wb_reg_d      = wb_reg_q;
        wb_en_d       = wb_en_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        ofl_exc_d     = ofl_exc_q;
        if (!stall) begin
            // Data registers load unconditionally; only the qualifiers honour flush/squash.
            result_d      = is_set ? {{(WIDTH-1){1'b0}}, c} : alu_out;
            wb_reg_d      = wr_reg;
            redirect_pc_d = br_target;
            if (flush) begin
                out_valid_d = 1'b0;
                wb_en_d     = 1'b0;
                redirect_d  = 1'b0;
            end else begin
                out_valid_d = live;
                wb_en_d     = live & wr_en;
                redirect_d  = live & is_branch & c;
`ifdef OFL_TRAP_EN
                if (ofl_exc_q) begin
                    out_valid_d = 1'b0;
                    wb_en_d     = 1'b0;
                end else if (live && is_arith && alu_ofl) begin
                    ofl_exc_d = 1'b1;
                    wb_en_d   = 1'b0;
                end
`endif
            end
            state_d = redirect_d ? SHADOW : NORMAL;
        end
    end

`ifndef OFL_TRAP_EN
    logic unused_is_arith;
    assign unused_is_arith = is_arith;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NORMAL;
            out_valid_q   <= 1'b0;
            result_q      <= '0;
            wb_reg_q      <= '0;
            wb_en_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            ofl_exc_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            result_q      <= result_d;
            wb_reg_q      <= wb_reg_d;
            wb_en_q       <= wb_en_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            ofl_exc_q     <= ofl_exc_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign wb_reg      = wb_reg_q;
    assign wb_en       = wb_en_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign ofl_exc     = ofl_exc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: capture, condition codes, squash shadow,
// stall/flush priority, reset recovery and the overflow trap option.
module tb_ex_result_stage;

    localparam int WIDTH = 16;
    localparam int REGW  = 3;

    logic             clk = 1'b0;
    logic             rst, in_valid, stall, flush;
    logic [WIDTH-1:0] alu_out, br_target;
    logic             alu_z, alu_ofl, alu_cout, alu_sign;
    logic [2:0]       cond;
    logic             is_set, is_branch, is_arith, wr_en;
    logic [REGW-1:0]  wr_reg;
    logic             out_valid, wb_en, redirect, ofl_exc;
    logic [WIDTH-1:0] result, redirect_pc;
    logic [REGW-1:0]  wb_reg;

    int checks   = 0;
    int failures = 0;

    ex_result_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_out(alu_out), .alu_z(alu_z), .alu_ofl(alu_ofl), .alu_cout(alu_cout),
        .alu_sign(alu_sign), .cond(cond), .is_set(is_set), .is_branch(is_branch),
        .is_arith(is_arith), .br_target(br_target), .wr_reg(wr_reg), .wr_en(wr_en),
        .out_valid(out_valid), .result(result), .wb_reg(wb_reg), .wb_en(wb_en),
        .redirect(redirect), .redirect_pc(redirect_pc), .ofl_exc(ofl_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rst = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        alu_out = '0; br_target = '0; alu_z = 1'b0; alu_ofl = 1'b0;
        alu_cout = 1'b0; alu_sign = 1'b0; cond = 3'b111; is_set = 1'b0;
        is_branch = 1'b0; is_arith = 1'b0; wr_en = 1'b0; wr_reg = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [15:0] val, input logic [2:0] rd);
        clr(); in_valid = 1'b1; wr_en = 1'b1; alu_out = val; wr_reg = rd;
    endtask

    task automatic set_op(input logic [2:0] cc, input logic z, input logic o,
                          input logic co, input logic s);
        clr(); in_valid = 1'b1; wr_en = 1'b1; is_set = 1'b1; alu_out = 16'hffff;
        cond = cc; alu_z = z; alu_ofl = o; alu_cout = co; alu_sign = s;
    endtask

    task automatic br_op(input logic [15:0] tgt, input logic [15:0] val);
        clr(); in_valid = 1'b1; is_branch = 1'b1; cond = 3'b000; alu_z = 1'b1;
        br_target = tgt; alu_out = val;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_wben", wb_en, 0);
        chk("rst_redir", redirect, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_ofl", ofl_exc, 0);

        // plain capture
        alu_op(16'h1234, 3'd3); step();
        chk("cap_valid", out_valid, 1);
        chk("cap_result", result, 16'h1234);
        chk("cap_wbreg", wb_reg, 3);
        chk("cap_wben", wb_en, 1);
        chk("cap_redir", redirect, 0);

        // condition codes through set instructions
        set_op(3'b010, 0, 1, 0, 1); step();
        chk("slt_ofl1", result, 16'h0000);
        set_op(3'b010, 0, 0, 0, 1); step();
        chk("slt_ofl0", result, 16'h0001);
        set_op(3'b101, 0, 0, 1, 0); step();
        chk("set_cout", result, 16'h0001);
        set_op(3'b100, 1, 0, 0, 0); step();
        chk("set_le_z", result, 16'h0001);
        set_op(3'b011, 0, 0, 0, 1); step();
        chk("set_ge", result, 16'h0000);
        set_op(3'b001, 1, 0, 0, 0); step();
        chk("set_ne", result, 16'h0000);
        set_op(3'b111, 1, 1, 1, 1); step();
        chk("set_never", result, 16'h0000);

        // taken branch, squashed follower (itself a would-be branch), then normal
        br_op(16'h0040, 16'h0000); step();
        chk("br_redir", redirect, 1);
        chk("br_rpc", redirect_pc, 16'h0040);
        alu_op(16'h9999, 3'd2); is_branch = 1'b1; cond = 3'b110; step();
        chk("sq_valid", out_valid, 0);
        chk("sq_wben", wb_en, 0);
        chk("sq_redir", redirect, 0);
        alu_op(16'h5555, 3'd5); step();
        chk("post_valid", out_valid, 1);
        chk("post_wben", wb_en, 1);
        chk("post_result", result, 16'h5555);

        // taken branch held through a 3-cycle stall
        br_op(16'h0080, 16'h0abc); step();
        alu_op(16'h1111, 3'd1); stall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_redir", redirect, 1);
            chk("stl_rpc", redirect_pc, 16'h0080);
            chk("stl_result", result, 16'h0abc);
            chk("stl_valid", out_valid, 1);
        end
        stall = 1'b0; flush = 1'b0; step();
        chk("stl_sq_valid", out_valid, 0);
        chk("stl_sq_redir", redirect, 0);
        alu_op(16'h2222, 3'd4); step();
        chk("stl_post_valid", out_valid, 1);

        // flush kills incoming; flush under stall is ignored
        alu_op(16'h3333, 3'd6); flush = 1'b1; step();
        chk("fl_valid", out_valid, 0);
        chk("fl_wben", wb_en, 0);
        alu_op(16'h7777, 3'd7); step();
        alu_op(16'h8888, 3'd0); flush = 1'b1; stall = 1'b1; step();
        chk("flst_valid", out_valid, 1);
        chk("flst_wben", wb_en, 1);
        chk("flst_result", result, 16'h7777);
        chk("flst_wbreg", wb_reg, 7);

        // flush while in the shadow still ends the shadow
        br_op(16'h00c0, 16'h0000); step();
        alu_op(16'h4444, 3'd1); flush = 1'b1; step();
        chk("shfl_valid", out_valid, 0);
        alu_op(16'h4545, 3'd1); step();
        chk("shfl_next", out_valid, 1);

        // reset during stall inside the shadow
        br_op(16'h0100, 16'h0000); step();
        clr(); rst = 1'b1; stall = 1'b1; step();
        chk("rsh_redir", redirect, 0);
        chk("rsh_rpc", redirect_pc, 0);
        chk("rsh_valid", out_valid, 0);
        alu_op(16'h6666, 3'd2); step();
        chk("rsh_next", out_valid, 1);

        // overflow on an arithmetic instruction
        alu_op(16'h7fff, 3'd3); is_arith = 1'b1; alu_ofl = 1'b1; step();
`ifdef OFL_TRAP_EN
        chk("trap_exc", ofl_exc, 1);
        chk("trap_wben", wb_en, 0);
        alu_op(16'h0001, 3'd1); step();
        chk("trap_next_valid", out_valid, 0);
        chk("trap_next_wben", wb_en, 0);
        chk("trap_sticky", ofl_exc, 1);
        clr(); rst = 1'b1; step();
        chk("trap_rst", ofl_exc, 0);
`else
        chk("ofl_exc_tied", ofl_exc, 0);
        chk("ofl_wben", wb_en, 1);
        alu_op(16'h0001, 3'd1); step();
        chk("ofl_next_valid", out_valid, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- EX/MEM boundary stage of the 16-bit pipelined core; the consumer side of the ALU result/flag interface.
- Registers the ALU result, flags and writeback control, then evaluates set/branch conditions from the flags.
- Produces the writeback value and a branch redirect to fetch.
- Squashes the single wrong-path instruction that follows a taken redirect.

Parameters:
- WIDTH, 16, datapath width of result, target and redirect PC.
- REGW, 3, register-specifier width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX holds a valid instruction this cycle
- stall  in  1  downstream stall; hold stage contents
- flush  in  1  kill the incoming instruction (not the held one)
- alu_out  in  WIDTH  ALU result
- alu_z  in  1  ALU zero flag
- alu_ofl  in  1  ALU overflow flag
- alu_cout  in  1  ALU carry out
- alu_sign  in  1  ALU result MSB
- cond  in  3  condition select
- is_set  in  1  set-type instruction; result becomes a condition bit
- is_branch  in  1  conditional branch
- is_arith  in  1  add/sub class, overflow-checked
- br_target  in  WIDTH  branch target PC
- wr_reg  in  REGW  destination register
- wr_en  in  1  instruction writes a register
- out_valid  out  1  stage holds a valid instruction
- result  out  WIDTH  writeback value
- wb_reg  out  REGW  destination register
- wb_en  out  1  qualified register write
- redirect  out  1  taken branch; fetch must load redirect_pc
- redirect_pc  out  WIDTH  redirect target
- ofl_exc  out  1  overflow exception (only meaningful with OFL_TRAP_EN)

Behaviour:
- Reset: all outputs 0; FSM state NORMAL.
- Update priority on each rising clk: rst > stall > flush > capture.
  - stall=1: every register and the FSM state hold, including redirect.
  - Fetch acts on redirect only in a cycle where stall=0.
  - stall=1 together with flush=1: the stage holds; flush is ignored.
- Condition bit c, from cond:
  - 000: Z
  - 001: ~Z
  - 010: sign^ofl (signed LT)
  - 011: ~(sign^ofl) (GE)
  - 100: Z|(sign^ofl) (LE)
  - 101: cout
  - 110: 1
  - 111: 0
- Capture, when not stalled and not flushed:
  - out_valid <= in_valid & ~squash
  - result <= is_set ? {WIDTH-1 zeros, c} : alu_out
  - wb_reg <= wr_reg
  - wb_en <= in_valid & ~squash & wr_en
  - redirect <= in_valid & ~squash & is_branch & c
  - redirect_pc <= br_target
- Flush, when not stalled: out_valid, wb_en and redirect load 0; data registers don't care.
- Latency: 1 cycle from EX inputs to outputs.
- FSM states: NORMAL and SHADOW; squash = (state==SHADOW).
  - NORMAL -> SHADOW: when a captured instruction sets redirect=1.
  - SHADOW -> NORMAL: on the next non-stalled clock, whether that cycle captures, squashes or flushes.
  - A squashed instruction never asserts redirect, so back-to-back branches cannot chain.
  - Stall in SHADOW: state holds.
- Width rule: flags are consumed as given; no internal arithmetic beyond the condition logic.
- Reset mid-stall or in SHADOW: returns to NORMAL with all outputs 0 on that edge.

Optional Feature:
- Macro: OFL_TRAP_EN.
- Defined, on a capture of a valid, non-squashed instruction:
  - is_arith & alu_ofl sets ofl_exc=1, sticky until rst.
  - That instruction's wb_en is forced to 0.
  - Further captures while ofl_exc=1 load out_valid=0 and wb_en=0.
- Undefined: ofl_exc tied 0; overflow is ignored and writeback proceeds.

Test Plan:
- Reset, then capture in_valid=1, wr_en=1, alu_out=16'h1234, wr_reg=3 -> next cycle out_valid=1, result=16'h1234, wb_reg=3, wb_en=1, redirect=0.
- SLT with cond=010, alu_sign=1, alu_ofl=1, is_set=1 -> result=16'h0000; same instruction with alu_ofl=0 -> result=16'h0001.
- Branch: is_branch=1, cond=000, alu_z=1, br_target=16'h0040 -> redirect=1, redirect_pc=16'h0040. The following in_valid instruction is squashed (out_valid=0, wb_en=0). The one after that captures normally.
- Capture a taken branch, then hold stall=1 for 3 cycles -> redirect stays 1 with all outputs unchanged. On stall release the next instruction is squashed.
- flush=1 with in_valid=1 -> out_valid=0, wb_en=0. flush=1 with stall=1 -> prior contents retained.
- OFL_TRAP_EN defined: is_arith=1, alu_ofl=1, wr_en=1 -> ofl_exc=1, wb_en=0. The subsequent valid instruction gives out_valid=0. rst clears ofl_exc to 0.
